// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-requester round-robin arbiter and access sequencer for Data_Memory
module data_mem_arbiter #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MEM_BYTES = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              r0_valid,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ready,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_err,
    input  logic              r1_valid,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ready,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 8);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_prio;
    logic              r_id;
    logic              r_write;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic              w_grant0;
    logic              w_grant1;
    logic              w_accept;
    logic              w_sel_write;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_resp;

    // Grants are only offered in IDLE; reset_n gates them so ready is low while reset is held.
    always_comb begin
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        w_state_nxt = r_state;
        if (r_state == S_IDLE && reset_n) begin
            w_grant0 = r0_valid & (~r1_valid | ~r_prio);
            w_grant1 = r1_valid & (~r0_valid |  r_prio);
        end
        w_accept    = w_grant0 | w_grant1;
        w_sel_write = w_grant1 ? r1_write : r0_write;
        w_sel_addr  = w_grant1 ? r1_addr  : r0_addr;
        w_sel_wdata = w_grant1 ? r1_wdata : r0_wdata;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_prio  <= 1'b0;
            r_id    <= 1'b0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_id    <= w_grant1;
                r_prio  <= w_grant0;
                r_write <= w_sel_write;
                r_addr  <= w_sel_addr;
                r_err   <= (w_sel_addr > LAST_ADDR);
                // Keep the last store data on the bus; loads leave it untouched.
                if (w_sel_write) begin
                    r_wdata <= w_sel_wdata;
                end
            end
            if (r_state == S_ISSUE) begin
                r_rdata <= (!r_err && !r_write) ? mem_rdata : '0;
            end
        end
    end

    assign w_resp    = (r_state == S_RESP);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_write = (r_state == S_ISSUE) & ~r_err &  r_write;
    assign mem_read  = (r_state == S_ISSUE) & ~r_err & ~r_write;

    assign r0_ready  = w_grant0;
    assign r1_ready  = w_grant1;
    assign r0_rvalid = w_resp & ~r_id;
    assign r1_rvalid = w_resp &  r_id;
    assign r0_rdata  = r0_rvalid ? r_rdata : '0;
    assign r1_rdata  = r1_rvalid ? r_rdata : '0;
    assign r0_err    = r0_rvalid & r_err;
    assign r1_err    = r1_rvalid & r_err;

endmodule
